iterative_divider: RTL

- Multi-cycle integer divide/remainder unit that sits directly downstream of the 2R/1W register file.
- Consumes the two read-port operands (rdDataA = dividend, rdDataB = divisor).
- Produces a write-back triple (wrData, wrNum, wrEnable) that drives the register file write port.
- Radix-2 restoring algorithm on magnitudes with final sign correction; holds a single operation at a time under a ready/start handshake.

---
 rtl/iterative_divider_pkg.sv | 45 ++++
 rtl/iterative_divider_div_step.sv | 24 ++
 rtl/iterative_divider.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/iterative_divider_pkg.sv
// Shared types for the iterative divide/remainder unit: widths, FSM states,
// request payload and a sign-magnitude helper.
package iterative_divider_pkg;

  localparam int unsigned DIV_DATA_WIDTH    = 32;
  localparam int unsigned DIV_REG_NUM_WIDTH = 5;
  localparam int unsigned DIV_STEP_COUNT    = DIV_DATA_WIDTH;
  localparam int unsigned DIV_COUNT_WIDTH   = $clog2(DIV_DATA_WIDTH);

  typedef logic [DIV_DATA_WIDTH-1:0]    data_t;
  typedef logic [DIV_REG_NUM_WIDTH-1:0] reg_num_t;
  typedef logic [DIV_COUNT_WIDTH-1:0]   count_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

  typedef struct packed {
    data_t    op_a;
    data_t    op_b;
    logic     is_signed;
    logic     is_rem;
    reg_num_t dst_num;
  } div_req_t;

  typedef struct packed {
    logic     is_rem;
    logic     quot_neg;
    logic     rem_neg;
    reg_num_t dst_num;
  } div_ctx_t;

  function automatic data_t negate(input data_t v);
    return data_t'(0) - v;
  endfunction

  // Magnitude of a two's-complement value; 0x80000000 maps to itself as unsigned.
  function automatic data_t magnitude(input data_t v, input logic is_signed);
    return (is_signed && v[DIV_DATA_WIDTH-1]) ? negate(v) : v;
  endfunction

endpackage

// File: rtl/iterative_divider_div_step.sv
// Single radix-2 restoring step: shift in one dividend bit, trial-subtract the
// divisor, keep or restore.
module iterative_divider_div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] i_rem,
  input  logic         i_dividend_bit,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_rem_c,
  output logic         o_quot_bit_c
);

  logic [W:0]   w_shifted;
  logic [W+1:0] w_trial;

  assign w_shifted = {i_rem, i_dividend_bit};

  // Extra guard bit makes the borrow the sign of the trial result.
  assign w_trial = {1'b0, w_shifted} - {2'b00, i_divisor};

  assign o_quot_bit_c = ~w_trial[W+1];
  assign o_rem_c      = o_quot_bit_c ? W'(w_trial) : W'(w_shifted);

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle signed/unsigned divide and remainder unit feeding the register
// file write port through a registered write-back triple.
module iterative_divider
  import iterative_divider_pkg::*;
(
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  output logic                         o_ready,
  input  logic [DIV_DATA_WIDTH-1:0]    i_op_a,
  input  logic [DIV_DATA_WIDTH-1:0]    i_op_b,
  input  logic                         i_is_signed,
  input  logic                         i_is_rem,
  input  logic [DIV_REG_NUM_WIDTH-1:0] i_dst_num,
  input  logic                         i_flush,
  output logic [DIV_DATA_WIDTH-1:0]    o_wr_data,
  output logic [DIV_REG_NUM_WIDTH-1:0] o_wr_num,
  output logic                         o_wr_enable,
  output logic                         o_div_by_zero
);

  localparam int unsigned MSB = DIV_DATA_WIDTH - 1;

  div_state_t r_state;
  div_state_t w_state_next;
  logic       r_ready;

  count_t     r_count;
  data_t      r_dividend;
  data_t      r_divisor;
  data_t      r_quot;
  data_t      r_rem;
  div_ctx_t   r_ctx;

  data_t      r_wr_data;
  reg_num_t   r_wr_num;
  logic       r_wr_enable;
  logic       r_div_by_zero;

  div_req_t   w_req;
  data_t      w_mag_a;
  data_t      w_mag_b;
  logic       w_div_zero;
  logic       w_accept;
  logic       w_step;
  logic       w_finish;
  data_t      w_step_rem;
  logic       w_step_qbit;
  data_t      w_quot_fix;
  data_t      w_rem_fix;
  data_t      w_result;

  assign w_req = '{op_a:      i_op_a,
                   op_b:      i_op_b,
                   is_signed: i_is_signed,
                   is_rem:    i_is_rem,
                   dst_num:   i_dst_num};

  assign w_mag_a    = magnitude(w_req.op_a, w_req.is_signed);
  assign w_mag_b    = magnitude(w_req.op_b, w_req.is_signed);
  assign w_div_zero = (w_req.op_b == '0);

  iterative_divider_div_step #(
    .W (DIV_DATA_WIDTH)
  ) u_div_step (
    .i_rem          (r_rem),
    .i_dividend_bit (r_dividend[MSB]),
    .i_divisor      (r_divisor),
    .o_rem_c        (w_step_rem),
    .o_quot_bit_c   (w_step_qbit)
  );

  assign w_quot_fix = r_ctx.quot_neg ? negate(r_quot) : r_quot;
  assign w_rem_fix  = r_ctx.rem_neg  ? negate(r_rem)  : r_rem;
  assign w_result   = r_ctx.is_rem   ? w_rem_fix      : w_quot_fix;

  // State register; ready tracks the next state so it is valid right after reset.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_ready <= (w_state_next == ST_IDLE);
    end
  end

  // Next-state and datapath control strobes; flush wins over start and write-back.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start && !i_flush) begin
          w_accept     = 1'b1;
          w_state_next = w_div_zero ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (i_flush) begin
          w_state_next = ST_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_count == DIV_COUNT_WIDTH'(DIV_STEP_COUNT - 1)) begin
            w_state_next = ST_FIX;
          end
        end
      end
      ST_FIX: begin
        if (i_flush) begin
          w_state_next = ST_IDLE;
        end else begin
          w_finish     = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Operand latch, restoring iteration and registered write-back.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_count       <= '0;
      r_dividend    <= '0;
      r_divisor     <= '0;
      r_quot        <= '0;
      r_rem         <= '0;
      r_ctx         <= '0;
      r_wr_data     <= '0;
      r_wr_num      <= '0;
      r_wr_enable   <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_wr_enable   <= 1'b0;
      r_div_by_zero <= 1'b0;

      if (w_accept) begin
        r_dividend <= w_mag_a;
        r_divisor  <= w_mag_b;
        r_quot     <= '0;
        r_rem      <= '0;
        r_count    <= '0;
        r_ctx      <= '{is_rem:   w_req.is_rem,
                        quot_neg: w_req.is_signed & (w_req.op_a[MSB] ^ w_req.op_b[MSB]),
                        rem_neg:  w_req.is_signed & w_req.op_a[MSB],
                        dst_num:  w_req.dst_num};
        if (w_div_zero) begin
          r_wr_data     <= w_req.is_rem ? w_req.op_a : '1;
          r_wr_num      <= w_req.dst_num;
          r_wr_enable   <= (w_req.dst_num != '0);
          r_div_by_zero <= 1'b1;
        end
      end

      if (w_step) begin
        r_rem      <= w_step_rem;
        r_quot     <= {r_quot[MSB-1:0], w_step_qbit};
        r_dividend <= {r_dividend[MSB-1:0], 1'b0};
        r_count    <= r_count + DIV_COUNT_WIDTH'(1);
      end

      if (w_finish) begin
        r_wr_data   <= w_result;
        r_wr_num    <= r_ctx.dst_num;
        r_wr_enable <= (r_ctx.dst_num != '0);
      end
    end
  end

  assign o_ready       = r_ready;
  assign o_wr_data     = r_wr_data;
  assign o_wr_num      = r_wr_num;
  assign o_wr_enable   = r_wr_enable;
  assign o_div_by_zero = r_div_by_zero;

endmodule
